// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB requester: single-beat cmd port to IDLE/SETUP/ACCESS transfers.
// Optional ACCESS wait-state abort is enabled with `APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SETUP  = 2'b01;
  localparam logic [1:0] S_ACCESS = 2'b10;

  logic [1:0] state;

  // Ready is masked by reset so every output reads 0 while Rst is held.
  assign cmd_ready = (state == S_IDLE) && !Rst;
  assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE   = (state == S_ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            if (cmd_write) PWDATA <= cmd_wdata;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          // Completion takes priority over an abort landing on the same edge.
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_error   <= PSLVERR;
            rsp_timeout <= 1'b0;
            state       <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign rsp_timeout = 1'b0;

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            if (cmd_write) PWDATA <= cmd_wdata;
            state  <= S_SETUP;
          end
        end
        S_SETUP: state <= S_ACCESS;
        S_ACCESS: begin
          // An unknown PREADY falls to the hold branch, i.e. another wait state.
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_error <= PSLVERR;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - self-checking bench for apb_master_ctrl with a memory-backed APB slave model.
module tb_apb_master_ctrl;

  logic       CLK = 1'b0;
  logic       Rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       rsp_timeout;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] mem [32];
  logic [7:0] pw_model;

  apb_master_ctrl #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full transfer with cycle-by-cycle phase checks; slave answers after 'waits' wait states.
  task automatic do_xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                         input int waits, input logic err);
    logic [7:0] exp_rd;
    total++;
    if ({cmd_ready, PSEL} !== 2'b10) begin
      bad++;
      $display("FAIL idle_ready: got ready=%b psel=%b want 1 0", cmd_ready, PSEL);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; PREADY = 1'b0;
    if (wr) pw_model = wd;
    exp_rd = wr ? 8'h00 : mem[a];
    tick();
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = 5'($urandom); cmd_wdata = 8'($urandom);
    total++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PADDR, PWDATA} !== {4'b1000, wr, a, pw_model}) begin
      bad++;
      $display("FAIL setup: got sel=%b en=%b rdy=%b rv=%b w=%b a=%h d=%h want 1000 w=%b a=%h d=%h",
               PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PADDR, PWDATA, wr, a, pw_model);
    end
    tick();
    for (int w = 0; w <= waits; w++) begin
      total++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PADDR, PWDATA} !== {4'b1100, wr, a, pw_model}) begin
        bad++;
        $display("FAIL access_%0d: got sel=%b en=%b rdy=%b rv=%b w=%b a=%h d=%h want 1100 w=%b a=%h d=%h",
                 w, PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PADDR, PWDATA, wr, a, pw_model);
      end
      if (w == waits) begin
        PREADY = 1'b1; PSLVERR = err;
        PRDATA = wr ? 8'($urandom) : mem[a];
      end else begin
        PREADY = ($urandom_range(0, 3) == 0) ? 1'bx : 1'b0;
        PSLVERR = 1'($urandom); PRDATA = 8'($urandom);
      end
      tick();
    end
    cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    if (wr && !err) mem[a] = wd;
    total++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata, PSEL, PENABLE, cmd_ready, PADDR, PWDATA}
        !== {1'b1, err, 1'b0, exp_rd, 3'b001, a, pw_model}) begin
      bad++;
      $display("FAIL rsp: got rv=%b err=%b to=%b rd=%h sel=%b en=%b rdy=%b a=%h d=%h want 1 %b 0 %h 001 %h %h",
               rsp_valid, rsp_error, rsp_timeout, rsp_rdata, PSEL, PENABLE, cmd_ready, PADDR, PWDATA,
               err, exp_rd, a, pw_model);
    end
  endtask

  task automatic start_xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; PREADY = 1'b0;
    if (wr) pw_model = wd;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 Rst = 1'b1;
    #2;
    total++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b to=%b sel=%b en=%b w=%b a=%h d=%h want all 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick(); tick();
    Rst = 1'b0;
    pw_model = 8'h00;
    #1;
    total++;
    if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b rv=%b sel=%b want 1 0 0", cmd_ready, rsp_valid, PSEL);
    end
    tick();
  endtask

  task automatic test_write();
    do_xfer(1'b1, 5'h03, 8'hA5, 0, 1'b0);
    tick();
    total++;
    if ({rsp_valid, PSEL, PADDR, PWDATA, PWRITE} !== {2'b00, 5'h03, 8'hA5, 1'b1}) begin
      bad++;
      $display("FAIL idle_hold: got rv=%b sel=%b a=%h d=%h w=%b want 0 0 03 a5 1",
               rsp_valid, PSEL, PADDR, PWDATA, PWRITE);
    end
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 5'h03, 8'h5A, 2, 1'b0);
    total++;
    if (rsp_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL read_a5: got %h want a5", rsp_rdata);
    end
    tick();
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, 5'h1F, 8'h00, 1, 1'b1);
    do_xfer(1'b1, 5'h1E, 8'h3C, 0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    start_xfer(1'b0, 5'h0A, 8'h00);
    tick();
    #2 Rst = 1'b1;
    #1;
    total++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: got sel=%b en=%b rv=%b rdy=%b want 0000", PSEL, PENABLE, rsp_valid, cmd_ready);
    end
    PREADY = 1'b1;
    tick();
    Rst = 1'b0;
    pw_model = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
        bad++;
        $display("FAIL reset_no_rsp_%0d: got rv=%b sel=%b rdy=%b want 0 0 1", i, rsp_valid, PSEL, cmd_ready);
      end
      tick();
    end
    PREADY = 1'b0;
  endtask

  task automatic test_timeout();
    start_xfer(1'b0, 5'h07, 8'h00);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
        bad++;
        $display("FAIL to_access_%0d: got sel=%b en=%b rv=%b want 110", i, PSEL, PENABLE, rsp_valid);
      end
      tick();
    end
    total++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata, PSEL, PENABLE, cmd_ready} !== {3'b111, 8'h00, 3'b001}) begin
      bad++;
      $display("FAIL timeout_rsp: got rv=%b err=%b to=%b rd=%h sel=%b en=%b rdy=%b want 111 00 001",
               rsp_valid, rsp_error, rsp_timeout, rsp_rdata, PSEL, PENABLE, cmd_ready);
    end
`else
    for (int i = 0; i < 100; i++) begin
      total++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b1100) begin
        bad++;
        $display("FAIL wait_forever_%0d: got sel=%b en=%b rv=%b rdy=%b want 1100",
                 i, PSEL, PENABLE, rsp_valid, cmd_ready);
      end
      tick();
    end
    PREADY = 1'b1; PRDATA = mem[7];
    tick();
    PREADY = 1'b0;
    total++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {3'b100, mem[7]}) begin
      bad++;
      $display("FAIL late_rsp: got rv=%b err=%b to=%b rd=%h want 1 0 0 %h",
               rsp_valid, rsp_error, rsp_timeout, rsp_rdata, mem[7]);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 5'h00, 8'h11, 0, 1'b0);
    do_xfer(1'b0, 5'h00, 8'hEE, 0, 1'b0);
    total++;
    if (rsp_rdata !== 8'h11) begin
      bad++;
      $display("FAIL b2b_read: got %h want 11", rsp_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_xfer(1'($urandom), 5'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        tick();
        total++;
        if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
          bad++;
          $display("FAIL rand_gap_%0d: got rv=%b sel=%b rdy=%b want 0 0 1", i, rsp_valid, PSEL, cmd_ready);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    pw_model = 8'h00;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
